// File: rtl/vga_timing_gen_if.sv
// Timing bundle fanned out from vga_timing_gen to the screen and overlay stages.
// The generator drives it through the master modport; consumers use slave.
interface vga_timing_gen_if;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic        frame_tick;
  logic [7:0]  frame_cnt;

  modport master (
    output hcount_out,
    output vcount_out,
    output hsync_out,
    output vsync_out,
    output hblnk_out,
    output vblnk_out,
    output frame_tick,
    output frame_cnt
  );

  modport slave (
    input hcount_out,
    input vcount_out,
    input hsync_out,
    input vsync_out,
    input hblnk_out,
    input vblnk_out,
    input frame_tick,
    input frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters, sync and blank flags, and a frame tick
// with a free-running frame counter. Defaults give 1024x768 @ 60 Hz on 65 MHz.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29
) (
  input  logic              pclk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [10:0] hcount_reg, hcount_next;
  logic [10:0] vcount_reg, vcount_next;
  logic        hsync_reg,  hsync_next;
  logic        vsync_reg,  vsync_next;
  logic        hblnk_reg,  hblnk_next;
  logic        vblnk_reg,  vblnk_next;
  logic        tick_reg,   tick_next;
  logic [7:0]  fcnt_reg,   fcnt_next;

  logic h_last;
  logic v_last;

  assign h_last = (hcount_reg == H_LAST);
  assign v_last = (vcount_reg == V_LAST);

  // Flags are decoded from the counts about to be loaded so they line up with them.
  always_comb begin
    hcount_next = hcount_reg + 11'd1;
    vcount_next = vcount_reg;
    tick_next   = 1'b0;
    fcnt_next   = fcnt_reg;

    if (h_last) begin
      hcount_next = 11'd0;
      if (v_last) begin
        vcount_next = 11'd0;
        tick_next   = 1'b1;
        fcnt_next   = fcnt_reg + 8'd1;
      end else begin
        vcount_next = vcount_reg + 11'd1;
      end
    end

    hblnk_next = (hcount_next >= H_ACT);
    vblnk_next = (vcount_next >= V_ACT);
    hsync_next = (hcount_next >= H_SYNC_BEG) && (hcount_next < H_SYNC_END);
    vsync_next = (vcount_next >= V_SYNC_BEG) && (vcount_next < V_SYNC_END);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_reg <= 11'd0;
      vcount_reg <= 11'd0;
      hsync_reg  <= 1'b0;
      vsync_reg  <= 1'b0;
      hblnk_reg  <= 1'b0;
      vblnk_reg  <= 1'b0;
      tick_reg   <= 1'b0;
      fcnt_reg   <= 8'd0;
    end else begin
      hcount_reg <= hcount_next;
      vcount_reg <= vcount_next;
      hsync_reg  <= hsync_next;
      vsync_reg  <= vsync_next;
      hblnk_reg  <= hblnk_next;
      vblnk_reg  <= vblnk_next;
      tick_reg   <= tick_next;
      fcnt_reg   <= fcnt_next;
    end
  end

  assign vga.hcount_out = hcount_reg;
  assign vga.vcount_out = vcount_reg;
  assign vga.hsync_out  = hsync_reg;
  assign vga.vsync_out  = vsync_reg;
  assign vga.hblnk_out  = hblnk_reg;
  assign vga.vblnk_out  = vblnk_reg;
  assign vga.frame_tick = tick_reg;
  assign vga.frame_cnt  = fcnt_reg;

endmodule
